dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Two-requester round-robin arbiter for the single data_mem port.
//   Requester 0 is the core load/store unit; requester 1 is the loader/debug port.
//   Serialises both onto data_mem: mem_write/mem_read/addr/write_data in, read_data out.
//   data_mem reads combinationally and writes on posedge clk.
//   A per-grant burst limit bounds how long one requester holds the memory.
// PARAMETERS
//   ADDR_W     32  address width of both requesters and memory
//   DATA_W     32  data width
//   MAX_BURST  4   max consecutive accesses per grant while the other port waits (>=1)
// PORTS
//   clk            in   1       clock; all state updates on posedge
//   rst            in   1       synchronous, active-high reset
//   req0/req1      in   1       access request, port 0 / port 1
//   we0/we1        in   1       1 = write, 0 = read
//   addr0/addr1    in   ADDR_W  byte address
//   wdata0/wdata1  in   DATA_W  write data
//   ack0/ack1      out  1       access performed this cycle
//   rdata0/rdata1  out  DATA_W  read data; valid when ack & ~we, else 0
//   owner          out  2       00 idle, 01 port0 granted, 10 port1 granted
//   mem_write      out  1       to data_mem
//   mem_read       out  1       to data_mem
//   mem_addr       out  ADDR_W  to data_mem
//   mem_wdata      out  DATA_W  to data_mem
//   mem_rdata      in   DATA_W  from data_mem (combinational)
// BEHAVIOUR
// - State regs: fsm in {IDLE, GNT0, GNT1}; prio (1 bit, port favoured on tie); beat_cnt (clog2(MAX_BURST)+1 bits).
// - Reset (rst high at posedge): fsm=IDLE, prio=0, beat_cnt=0.
// - While rst is high, the following are forced to 0 combinationally regardless of fsm, so no write lands mid-reset:
//   ack0, ack1, mem_write, mem_read, mem_addr, mem_wdata, rdata0, rdata1.
// - IDLE:
//   - No ack; all mem_* outputs 0; owner=00.
//   - Only req0 -> GNT0. Only req1 -> GNT1. Both -> GNT<prio>.
//   - beat_cnt <= 0 on entry to any GNT state.
// - GNTx:
//   - owner=x; mem_addr/mem_wdata driven from port x.
//   - If req_x: ack_x=1; mem_write=we_x; mem_read=~we_x; rdata_x=mem_rdata when ~we_x.
//     The write commits at the posedge ending this cycle.
//   - If ~req_x (request dropped): no access, no ack, mem_write=mem_read=0.
//     Next state is GNT<other> if req_other, else IDLE.
//   - If req_x and beat_cnt==MAX_BURST-1:
//     - req_other -> GNT<other>, beat_cnt<=0.
//     - else stay in GNTx, beat_cnt<=0.
//   - Otherwise, if req_x: stay, beat_cnt<=beat_cnt+1.
//   - prio <= ~x on every cycle ack_x=1 (loser of last access gets the next tie).
// - The non-granted port's ack and rdata are always 0.
// - Latency: req from IDLE -> ack 1 cycle later. Back-to-back accesses while granted: 1 per cycle.
// - Handshake:
//   - Requester holds req/we/addr/wdata stable until the ack cycle.
//   - After ack it may drop req or present the next access in the following cycle.
//   - Dropping req before ack aborts with no memory side effect.
// - Port handover costs 0 idle cycles at burst limit, 1 cycle when the owner drops req.
// - Arbiter does no address decoding or alignment; addresses pass through unchanged.
// TESTING
// 1. Reset:
//    - rst=1 for 2 cycles while req0=1, we0=1 -> ack0=0, mem_write=0 throughout.
//    - Memory word 0 unchanged; owner=00 after release.
// 2. Single port 0 write-then-read:
//    - Write 0xABCDDEAD @0x0 -> ack0 one cycle after req.
//    - Read @0x0 -> rdata0=0xABCDDEAD in the ack cycle.
// 3. Simultaneous req0=req1 from IDLE after reset:
//    - Port 0 granted first (prio=0).
//    - Next tie goes to port 1.
// 4. Burst limit with MAX_BURST=4:
//    - req0 held for 10 writes, req1 asserted at the same time.
//    - Expect 4 ack0, then 4 ack1, then ack0 resumes; no dead cycle at handovers.
// 5. Port 1 alone, continuous req for 6 cycles -> 6 consecutive ack1; grant never leaves GNT1.
// 6. Abort:
//    - req1 asserted with we1=1, addr=0x4, wdata=0xA1B2C3D4, dropped while port 0 owns the port.
//    - No write: reading 0x4 afterwards returns its prior value.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the data_mem port seen by dmem_arbiter.
// Handshake: a requester holds req/we/addr/wdata stable until the cycle ack is high; that
// cycle performs the access (rdata valid on reads, write commits at the closing posedge).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [1:0]        owner;
  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters plus the memory model.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, owner, mem_write, mem_read, mem_addr, mem_wdata
  );

  // The arbiter itself.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, owner, mem_write, mem_read, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single data_mem port, with a per-grant
// burst limit so one requester cannot starve the other.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  dmem_arbiter_if.slave bus,
  output logic [1:0]   dbg_state,
  output logic         dbg_prio
);

  localparam int BEAT_W = $clog2(MAX_BURST) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              prio;
  logic              prio_nxt;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] beat_nxt;

  logic              gnt1;
  logic              own_req;
  logic              oth_req;
  logic              own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  state_t            oth_state;

  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [1:0]        owner;
  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Port-agnostic view of whoever currently holds the grant.
  assign gnt1      = (state == GNT1);
  assign own_req   = gnt1 ? bus.req1   : bus.req0;
  assign oth_req   = gnt1 ? bus.req0   : bus.req1;
  assign own_we    = gnt1 ? bus.we1    : bus.we0;
  assign own_addr  = gnt1 ? bus.addr1  : bus.addr0;
  assign own_wdata = gnt1 ? bus.wdata1 : bus.wdata0;
  assign oth_state = gnt1 ? GNT0 : GNT1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      prio     <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      prio     <= prio_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    beat_nxt  = beat_cnt;
    ack0      = 1'b0;
    ack1      = 1'b0;
    rdata0    = '0;
    rdata1    = '0;
    owner     = 2'b00;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state)
      IDLE: begin
        beat_nxt = '0;
        if (bus.req0 && (!bus.req1 || !prio)) begin
          state_nxt = GNT0;
        end else if (bus.req1) begin
          state_nxt = GNT1;
        end
      end

      GNT0, GNT1: begin
        owner     = gnt1 ? 2'b10 : 2'b01;
        mem_addr  = own_addr;
        mem_wdata = own_wdata;
        if (!own_req) begin
          // Owner let go: hand over immediately if the other port waits.
          state_nxt = oth_req ? oth_state : IDLE;
          beat_nxt  = '0;
        end else begin
          mem_write = own_we;
          mem_read  = ~own_we;
          prio_nxt  = ~gnt1;
          if (gnt1) begin
            ack1   = 1'b1;
            rdata1 = own_we ? '0 : bus.mem_rdata;
          end else begin
            ack0   = 1'b1;
            rdata0 = own_we ? '0 : bus.mem_rdata;
          end
          if (beat_cnt == LAST_BEAT) begin
            beat_nxt = '0;
            if (oth_req) begin
              state_nxt = oth_state;
            end
          end else begin
            beat_nxt = beat_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        beat_nxt  = '0;
      end
    endcase

    // Reset masks every memory-side effect so nothing lands mid-reset.
    if (rst) begin
      ack0      = 1'b0;
      ack1      = 1'b0;
      rdata0    = '0;
      rdata1    = '0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  assign bus.ack0      = ack0;
  assign bus.ack1      = ack1;
  assign bus.rdata0    = rdata0;
  assign bus.rdata1    = rdata1;
  assign bus.owner     = owner;
  assign bus.mem_write = mem_write;
  assign bus.mem_read  = mem_read;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

  assign dbg_state = state;
  assign dbg_prio  = prio;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, all checked cycle by cycle
// against a grant/burst reference model and a shadow copy of data memory.
module tb_dmem_arbiter;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;
  localparam int MEM_WORDS = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] dbg_state;
  logic       dbg_prio;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_prio  (dbg_prio)
  );

  // data_mem: combinational read, write on posedge
  logic [DATA_W-1:0] mem     [MEM_WORDS];
  logic [DATA_W-1:0] ref_mem [MEM_WORDS];
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int          m_owner = 0;  // 0 nobody, 1 port0, 2 port1
  bit          m_prio  = 1'b0;
  int          m_used  = 0;  // accesses served in the current grant window
  logic        obs_ack0, obs_ack1;
  logic [1:0]  obs_owner;
  logic [DATA_W-1:0] obs_rdata0, obs_rdata1;
  logic [1:0]  exp_q[$];     // expected order of served ports

  task automatic model_check();
    logic e_ack0, e_ack1, e_wr, e_rd, mine, other;
    logic [1:0] e_owner;
    logic [DATA_W-1:0] e_rd0, e_rd1;
    logic [ADDR_W-1:0] e_addr;
    obs_ack0   = bus.ack0;
    obs_ack1   = bus.ack1;
    obs_owner  = bus.owner;
    obs_rdata0 = bus.rdata0;
    obs_rdata1 = bus.rdata1;
    if (rst) begin
      checks++;
      if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.mem_write !== 1'b0 ||
          bus.mem_read !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0 ||
          bus.rdata0 !== '0 || bus.rdata1 !== '0) begin
        errors++;
        $display("FAIL reset_force: ack0=%b ack1=%b wr=%b rd=%b addr=%h wdata=%h, required all 0",
                 bus.ack0, bus.ack1, bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata);
      end
      m_owner = 0; m_prio = 1'b0; m_used = 0;
      return;
    end
    e_ack0  = (m_owner == 1) && bus.req0;
    e_ack1  = (m_owner == 2) && bus.req1;
    e_owner = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    e_wr    = (e_ack0 && bus.we0) || (e_ack1 && bus.we1);
    e_rd    = (e_ack0 && !bus.we0) || (e_ack1 && !bus.we1);
    e_rd0   = (e_ack0 && !bus.we0) ? ref_mem[bus.addr0[9:2]] : '0;
    e_rd1   = (e_ack1 && !bus.we1) ? ref_mem[bus.addr1[9:2]] : '0;
    e_addr  = (m_owner == 1) ? bus.addr0 : (m_owner == 2) ? bus.addr1 : '0;

    checks++;
    if (bus.ack0 !== e_ack0) begin errors++; $display("FAIL ack0 @%0t: got %b want %b", $time, bus.ack0, e_ack0); end
    checks++;
    if (bus.ack1 !== e_ack1) begin errors++; $display("FAIL ack1 @%0t: got %b want %b", $time, bus.ack1, e_ack1); end
    checks++;
    if (bus.owner !== e_owner) begin errors++; $display("FAIL owner @%0t: got %b want %b", $time, bus.owner, e_owner); end
    checks++;
    if (bus.mem_write !== e_wr || bus.mem_read !== e_rd) begin
      errors++;
      $display("FAIL mem_ctl @%0t: wr=%b rd=%b want wr=%b rd=%b", $time, bus.mem_write, bus.mem_read, e_wr, e_rd);
    end
    checks++;
    if (bus.mem_addr !== e_addr) begin errors++; $display("FAIL mem_addr @%0t: got %h want %h", $time, bus.mem_addr, e_addr); end
    checks++;
    if (bus.rdata0 !== e_rd0) begin errors++; $display("FAIL rdata0 @%0t: got %h want %h", $time, bus.rdata0, e_rd0); end
    checks++;
    if (bus.rdata1 !== e_rd1) begin errors++; $display("FAIL rdata1 @%0t: got %h want %h", $time, bus.rdata1, e_rd1); end

    if (e_ack0 && bus.we0) ref_mem[bus.addr0[9:2]] = bus.wdata0;
    if (e_ack1 && bus.we1) ref_mem[bus.addr1[9:2]] = bus.wdata1;

    // Grant bookkeeping for the next cycle.
    if (m_owner == 0) begin
      m_used = 0;
      if (bus.req0 && bus.req1) m_owner = m_prio ? 2 : 1;
      else if (bus.req0)        m_owner = 1;
      else if (bus.req1)        m_owner = 2;
    end else begin
      mine  = (m_owner == 1) ? bus.req0 : bus.req1;
      other = (m_owner == 1) ? bus.req1 : bus.req0;
      if (!mine) begin
        m_owner = other ? 3 - m_owner : 0;
        m_used  = 0;
      end else begin
        m_prio = (m_owner == 1);
        m_used++;
        if (m_used == MAX_BURST) begin
          m_used = 0;
          if (other) m_owner = 3 - m_owner;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic r, input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
  endtask

  task automatic set1(input logic r, input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set0(0, 0, '0, '0);
    set1(0, 0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    mem[0] = 32'h1111_1111; ref_mem[0] = 32'h1111_1111;
    rst = 1'b1;
    set0(1, 1, 32'h0, 32'hDEAD_BEEF);
    set1(0, 0, '0, '0);
    repeat (2) begin
      tick();
      checks++;
      if (obs_ack0 !== 1'b0) begin errors++; $display("FAIL reset_ack0: got %b want 0", obs_ack0); end
    end
    rst = 1'b0;
    set0(0, 0, '0, '0);
    tick();
    checks++;
    if (obs_owner !== 2'b00) begin errors++; $display("FAIL reset_owner: got %b want 00", obs_owner); end
    checks++;
    if (mem[0] !== 32'h1111_1111) begin errors++; $display("FAIL reset_mem0: got %h want 11111111", mem[0]); end
    set0(1, 0, 32'h0, '0);
    tick();
    tick();
    checks++;
    if (obs_ack0 !== 1'b1 || obs_rdata0 !== 32'h1111_1111) begin
      errors++; $display("FAIL reset_readback: ack=%b data=%h want ack=1 data=11111111", obs_ack0, obs_rdata0);
    end
    set0(0, 0, '0, '0);
    tick();
  endtask

  task automatic test_write_read();
    set0(1, 1, 32'h0, 32'hABCD_DEAD);
    tick();
    checks++;
    if (obs_ack0 !== 1'b0) begin errors++; $display("FAIL wr_latency_early: ack0=%b want 0", obs_ack0); end
    tick();
    checks++;
    if (obs_ack0 !== 1'b1) begin errors++; $display("FAIL wr_latency: ack0=%b want 1", obs_ack0); end
    set0(1, 0, 32'h0, '0);
    tick();
    checks++;
    if (obs_ack0 !== 1'b1 || obs_rdata0 !== 32'hABCD_DEAD) begin
      errors++; $display("FAIL rd_after_wr: ack=%b data=%h want ack=1 data=abcddead", obs_ack0, obs_rdata0);
    end
    set0(0, 0, '0, '0);
    tick();
    tick();
  endtask

  task automatic test_tie();
    do_reset();
    set0(1, 0, 32'h8, '0);
    set1(1, 0, 32'hC, '0);
    tick();
    tick();
    checks++;
    if (obs_ack0 !== 1'b1 || obs_ack1 !== 1'b0) begin
      errors++; $display("FAIL tie_first: ack0=%b ack1=%b want 1/0", obs_ack0, obs_ack1);
    end
    set0(0, 0, '0, '0);
    set1(0, 0, '0, '0);
    tick();
    tick();
    set0(1, 0, 32'h8, '0);
    set1(1, 0, 32'hC, '0);
    tick();
    tick();
    checks++;
    if (obs_ack0 !== 1'b0 || obs_ack1 !== 1'b1) begin
      errors++; $display("FAIL tie_second: ack0=%b ack1=%b want 0/1", obs_ack0, obs_ack1);
    end
    set0(0, 0, '0, '0);
    set1(0, 0, '0, '0);
    tick();
    tick();
  endtask

  task automatic test_burst();
    int rem0 = 10;
    int rem1 = 4;
    int cyc = 0;
    int first = -1;
    int last = -1;
    logic [1:0] got, want;
    do_reset();
    exp_q.delete();
    repeat (4) exp_q.push_back(2'd0);
    repeat (4) exp_q.push_back(2'd1);
    repeat (6) exp_q.push_back(2'd0);
    while ((rem0 > 0 || rem1 > 0) && cyc < 40) begin
      set0(rem0 > 0, 1, ADDR_W'(32'h100 + 4 * (10 - rem0)), DATA_W'(32'hB000_0000 + rem0));
      set1(rem1 > 0, 1, ADDR_W'(32'h200 + 4 * (4 - rem1)), DATA_W'(32'hC000_0000 + rem1));
      tick();
      if (obs_ack0 || obs_ack1) begin
        if (first < 0) first = cyc;
        last = cyc;
        got = obs_ack1 ? 2'd1 : 2'd0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL burst_order: extra ack from port %0d", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin errors++; $display("FAIL burst_order: port %0d acked, want port %0d", got, want); end
        end
      end
      if (obs_ack0) rem0--;
      if (obs_ack1) rem1--;
      cyc++;
    end
    checks++;
    if (rem0 != 0 || rem1 != 0) begin errors++; $display("FAIL burst_timeout: rem0=%0d rem1=%0d want 0/0", rem0, rem1); end
    checks++;
    if (last - first + 1 != 14) begin errors++; $display("FAIL burst_dead_cycles: span=%0d want 14", last - first + 1); end
    set0(0, 0, '0, '0);
    set1(0, 0, '0, '0);
    tick();
    tick();
  endtask

  task automatic test_port1_alone();
    do_reset();
    set1(1, 0, 32'h20, '0);
    tick();
    for (int i = 0; i < 6; i++) begin
      set1(1, 1'($urandom_range(0, 1)), ADDR_W'(32'h20 + 4 * i), DATA_W'($urandom));
      tick();
      checks++;
      if (obs_ack1 !== 1'b1 || obs_owner !== 2'b10) begin
        errors++; $display("FAIL port1_stream[%0d]: ack1=%b owner=%b want 1/10", i, obs_ack1, obs_owner);
      end
    end
    set1(0, 0, '0, '0);
    tick();
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    mem[1] = 32'h55AA_55AA; ref_mem[1] = 32'h55AA_55AA;
    set0(1, 0, 32'h40, '0);
    tick();
    tick();
    set1(1, 1, 32'h4, 32'hA1B2_C3D4);
    repeat (2) begin
      tick();
      checks++;
      if (obs_ack1 !== 1'b0) begin errors++; $display("FAIL abort_ack1: got %b want 0", obs_ack1); end
    end
    set1(0, 0, '0, '0);
    tick();
    set0(0, 0, '0, '0);
    tick();
    set1(1, 0, 32'h4, '0);
    tick();
    tick();
    checks++;
    if (obs_ack1 !== 1'b1 || obs_rdata1 !== 32'h55AA_55AA) begin
      errors++; $display("FAIL abort_no_write: ack=%b data=%h want ack=1 data=55aa55aa", obs_ack1, obs_rdata1);
    end
    set1(0, 0, '0, '0);
    tick();
  endtask

  task automatic test_random();
    logic act0 = 1'b0, act1 = 1'b0;
    int bad = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (act0 && $urandom_range(0, 15) == 0) act0 = 1'b0;
      if (act1 && $urandom_range(0, 15) == 0) act1 = 1'b0;
      if (!act0 && $urandom_range(0, 2) != 0) begin
        act0 = 1'b1;
        set0(1, 1'($urandom_range(0, 1)), ADDR_W'(4 * $urandom_range(0, 31)), DATA_W'($urandom));
      end
      if (!act1 && $urandom_range(0, 2) != 0) begin
        act1 = 1'b1;
        set1(1, 1'($urandom_range(0, 1)), ADDR_W'(4 * $urandom_range(0, 31)), DATA_W'($urandom));
      end
      bus.req0 = act0;
      bus.req1 = act1;
      tick();
      if (obs_ack0) act0 = 1'b0;
      if (obs_ack1) act1 = 1'b0;
    end
    set0(0, 0, '0, '0);
    set1(0, 0, '0, '0);
    tick();
    tick();
    for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL mem_image: %0d words differ, want 0", bad); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i]     = DATA_W'(32'h1000_0000 + i);
      ref_mem[i] = DATA_W'(32'h1000_0000 + i);
    end
    set0(0, 0, '0, '0);
    set1(0, 0, '0, '0);
    test_reset();
    test_write_read();
    test_tie();
    test_burst();
    test_port1_alone();
    test_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
